// File: rtl/nn_result_scorer.sv
// rtl/nn_result_scorer.sv - scores network results against labels and divides out percent accuracy
`timescale 1ns/1ps
module nn_result_scorer #(
    parameter int NUM_SAMPLES = 750,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [9:0]        sample_idx,
    output logic              net_start,
    input  logic              net_ready,
    input  logic [DATA_W-1:0] net_result,
    input  logic [DATA_W-1:0] label,
    output logic [9:0]        correct_count,
    output logic [6:0]        accuracy,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DIVIDE,
        S_DONE
    } state_t;

    localparam logic [9:0]  LAST_IDX = 10'(NUM_SAMPLES - 1);
    localparam logic [10:0] DIVISOR  = 11'(NUM_SAMPLES);

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [9:0]  count_q, count_d;
    logic [6:0]  acc_q, acc_d;
    logic        net_ready_d_q, net_ready_d_d;
    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    logic [16:0] dvd_q, dvd_d;
    logic [9:0]  rem_q, rem_d;
    logic [4:0]  bit_q, bit_d;

    logic        accept;
    logic        match;
    logic [9:0]  count_inc;
    logic [10:0] rem_shift;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        acc_d         = acc_q;
        net_ready_d_d = net_ready;
        dvd_d         = dvd_q;
        rem_d         = rem_q;
        bit_d         = bit_q;

        // A level still high from the previous sample is already in net_ready_d, so only a fresh edge counts.
        accept    = (state_q == S_WAIT) && net_ready && !net_ready_d_q;
        match     = (net_result == label);
        count_inc = count_q + {9'd0, match};
        rem_shift = {rem_q, dvd_q[16]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d   = 10'd0;
                    count_d = 10'd0;
                    acc_d   = 7'd0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (accept) begin
                    count_d = count_inc;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DIVIDE;
                        dvd_d   = 17'(count_inc) * 17'd100;
                        rem_d   = 10'd0;
                        bit_d   = 5'd0;
                    end else begin
                        idx_d   = idx_q + 10'd1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DIVIDE: begin
                if (rem_shift >= DIVISOR) begin
                    rem_d = 10'(rem_shift - DIVISOR);
                    dvd_d = {dvd_q[15:0], 1'b1};
                end else begin
                    rem_d = rem_shift[9:0];
                    dvd_d = {dvd_q[15:0], 1'b0};
                end
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd16) begin
                    state_d = S_DONE;
                    acc_d   = dvd_d[6:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 10'd0;
            count_q       <= 10'd0;
            acc_q         <= 7'd0;
            net_ready_d_q <= 1'b0;
            dvd_q         <= 17'd0;
            rem_q         <= 10'd0;
            bit_q         <= 5'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
            net_ready_d_q <= net_ready_d_d;
            dvd_q         <= dvd_d;
            rem_q         <= rem_d;
            bit_q         <= bit_d;
        end
    end

    assign sample_idx    = idx_q;
    assign correct_count = count_q;
    assign accuracy      = acc_q;
    assign net_start     = (state_q == S_LAUNCH);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);

endmodule
